ram_dual_port: RTL and testbench

RAM_DUAL_PORT -- requirements
Module: ram_dual_port

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_clear_seq.sv | 69 ++++++
 rtl/ram_dual_port.sv | 126 ++++++++++++
 tb/tb_ram_dual_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// ram_pkg : clear-sequencer state encoding and collision-mode constants
// Revision: 1.0
// ============================================================================
package ram_pkg;

  typedef enum logic [0:0] {
    CLEARING = 1'b0,
    READY    = 1'b1
  } state_t;

  localparam int c_read_first  = 0;
  localparam int c_write_first = 1;

endpackage
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
// ram_clear_seq : walks the array writing zeros, one word per cycle
// Revision: 1.0
// ============================================================================
module ram_clear_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] CLR_ADDR,
  output logic                  CLR_WE
);
  import ram_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= CLEARING;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A clear request always wins, including on the last clear cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEARING: begin
        if (CLR) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_last) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      READY: begin
        if (CLR) begin
          w_state_nxt = CLEARING;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEARING;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign BUSY     = (r_state == CLEARING);
  assign CLR_WE   = BUSY;
  assign CLR_ADDR = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ram_dual_port.sv
`default_nettype none
// ============================================================================
// ram_dual_port : 1W/1R + 1R dual-port RAM with self-clearing sequencer
// Option macro RAM_PARITY_EN adds a stored even-parity bit and PERR_A/PERR_B.
// Revision: 1.0
// ============================================================================
module ram_dual_port #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 10,
  parameter int MEM_SIZE    = 256,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  EN_A,
  input  logic                  WE_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  input  logic [DATA_WIDTH-1:0] DIN_A,
  output logic [DATA_WIDTH-1:0] DOUT_A,
  output logic                  VLD_A,
  input  logic                  EN_B,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  output logic [DATA_WIDTH-1:0] DOUT_B,
  output logic                  VLD_B,
  output logic                  BUSY
`ifdef RAM_PARITY_EN
  ,
  output logic                  PERR_A,
  output logic                  PERR_B
`endif
);
  import ram_pkg::*;

`ifdef RAM_PARITY_EN
  localparam int c_mem_w = DATA_WIDTH + 1;
`else
  localparam int c_mem_w = DATA_WIDTH;
`endif
  localparam int                  c_idx_w    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] c_mem_size = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [c_mem_w-1:0]    r_mem [MEM_SIZE];
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_clr_we;
  logic                  w_a_in;
  logic                  w_b_in;
  logic                  w_a_wr;
  logic                  w_a_rd;
  logic                  w_b_rd;
  logic                  w_b_fwd;
  logic [c_mem_w-1:0]    w_wr_word;
  logic [c_mem_w-1:0]    w_word_a;
  logic [c_mem_w-1:0]    w_word_b;

  ram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_clear_seq (
    .CLK      (CLK),
    .RST      (RST),
    .CLR      (CLR),
    .BUSY     (w_busy),
    .CLR_ADDR (w_clr_addr),
    .CLR_WE   (w_clr_we)
  );

  assign BUSY   = w_busy;
  assign w_a_in = ({1'b0, ADDR_A} < c_mem_size);
  assign w_b_in = ({1'b0, ADDR_B} < c_mem_size);
  assign w_a_wr = !w_busy && EN_A && WE_A && w_a_in;
  assign w_a_rd = !w_busy && EN_A && !WE_A;
  assign w_b_rd = !w_busy && EN_B;

`ifdef RAM_PARITY_EN
  assign w_wr_word = {^DIN_A, DIN_A};
`else
  assign w_wr_word = DIN_A;
`endif

  // Write-first mode forwards port A's write data straight to port B.
  assign w_b_fwd  = (WRITE_FIRST == c_write_first) && w_a_wr && (ADDR_A == ADDR_B);
  assign w_word_a = w_a_in ? r_mem[ADDR_A[c_idx_w-1:0]] : '0;
  assign w_word_b = !w_b_in ? '0 : (w_b_fwd ? w_wr_word : r_mem[ADDR_B[c_idx_w-1:0]]);

  always_ff @(posedge CLK) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr[c_idx_w-1:0]] <= '0;
    end else if (w_a_wr) begin
      r_mem[ADDR_A[c_idx_w-1:0]] <= w_wr_word;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT_A <= '0;
      DOUT_B <= '0;
      VLD_A  <= 1'b0;
      VLD_B  <= 1'b0;
    end else begin
      VLD_A <= w_a_rd;
      VLD_B <= w_b_rd;
      if (w_a_rd) begin
        DOUT_A <= w_word_a[DATA_WIDTH-1:0];
      end
      if (w_b_rd) begin
        DOUT_B <= w_word_b[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PERR_A <= 1'b0;
      PERR_B <= 1'b0;
    end else begin
      PERR_A <= w_a_rd && (^w_word_a);
      PERR_B <= w_b_rd && (^w_word_b);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dual_port.sv
`default_nettype none
// ============================================================================
// tb_ram_dual_port : random and directed stimulus against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_ram_dual_port;

  localparam int AW = 10;
  localparam int DW = 10;
  localparam int MS = 256;
  localparam int WF = 0;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CLR;
  logic          EN_A;
  logic          WE_A;
  logic [AW-1:0] ADDR_A;
  logic [DW-1:0] DIN_A;
  logic [DW-1:0] DOUT_A;
  logic          VLD_A;
  logic          EN_B;
  logic [AW-1:0] ADDR_B;
  logic [DW-1:0] DOUT_B;
  logic          VLD_B;
  logic          BUSY;
`ifdef RAM_PARITY_EN
  logic          PERR_A;
  logic          PERR_B;
`endif

  ram_dual_port #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_SIZE    (MS),
    .WRITE_FIRST (WF)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (CLR),
    .EN_A   (EN_A),
    .WE_A   (WE_A),
    .ADDR_A (ADDR_A),
    .DIN_A  (DIN_A),
    .DOUT_A (DOUT_A),
    .VLD_A  (VLD_A),
    .EN_B   (EN_B),
    .ADDR_B (ADDR_B),
    .DOUT_B (DOUT_B),
    .VLD_B  (VLD_B),
    .BUSY   (BUSY)
`ifdef RAM_PARITY_EN
    ,
    .PERR_A (PERR_A),
    .PERR_B (PERR_B)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: array contents plus "clearing, next word to zero".
  int m_mem [MS];
  bit m_flip [MS];
  bit m_busy;
  int m_pos;
  int m_dout_a, m_dout_b;
  bit m_vld_a, m_vld_b, m_perr_a, m_perr_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    CLR = 1'b0; EN_A = 1'b0; WE_A = 1'b0; EN_B = 1'b0;
    ADDR_A = '0; ADDR_B = '0; DIN_A = '0;
  endtask

  task automatic rand_req(input int amax);
    EN_A   = 1'($urandom_range(0, 1));
    WE_A   = 1'($urandom_range(0, 1));
    EN_B   = 1'($urandom_range(0, 1));
    ADDR_A = AW'($urandom_range(0, amax));
    ADDR_B = ($urandom_range(0, 3) == 0) ? ADDR_A : AW'($urandom_range(0, amax));
    DIN_A  = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  task automatic model_edge();
    int  a  = int'(ADDR_A);
    int  b  = int'(ADDR_B);
    bit  wr = EN_A && WE_A;
    if (m_busy) begin
      m_mem[m_pos]  = 0;
      m_flip[m_pos] = 1'b0;
      if (CLR) m_pos = 0;
      else begin
        m_pos++;
        if (m_pos == MS) m_busy = 1'b0;
      end
      m_vld_a = 1'b0; m_vld_b = 1'b0; m_perr_a = 1'b0; m_perr_b = 1'b0;
    end else begin
      m_vld_b  = EN_B;
      m_perr_b = 1'b0;
      if (EN_B) begin
        if (b >= MS) m_dout_b = 0;
        else if (WF == 1 && wr && a == b) m_dout_b = int'(DIN_A);
        else begin
          m_dout_b = m_mem[b];
          m_perr_b = m_flip[b];
        end
      end
      m_vld_a  = EN_A && !WE_A;
      m_perr_a = 1'b0;
      if (m_vld_a) begin
        m_dout_a = (a < MS) ? m_mem[a] : 0;
        m_perr_a = (a < MS) ? m_flip[a] : 1'b0;
      end
      if (wr && a < MS) begin
        m_mem[a]  = int'(DIN_A);
        m_flip[a] = 1'b0;
      end
      if (CLR) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check("busy",   32'(BUSY),   32'(m_busy));
    check("vld_a",  32'(VLD_A),  32'(m_vld_a));
    check("vld_b",  32'(VLD_B),  32'(m_vld_b));
    check("dout_a", 32'(DOUT_A), 32'(m_dout_a));
    check("dout_b", 32'(DOUT_B), 32'(m_dout_b));
`ifdef RAM_PARITY_EN
    check("perr_a", 32'(PERR_A), 32'(m_perr_a));
    check("perr_b", 32'(PERR_B), 32'(m_perr_b));
`endif
    @(negedge CLK);
  endtask

  task automatic do_reset(input int hold);
    idle();
    RST = 1'b1;
    #1;
    check("rst_busy",   32'(BUSY),   32'd1);
    check("rst_dout_a", 32'(DOUT_A), 32'd0);
    check("rst_dout_b", 32'(DOUT_B), 32'd0);
    check("rst_vld_a",  32'(VLD_A),  32'd0);
    check("rst_vld_b",  32'(VLD_B),  32'd0);
    m_busy = 1'b1; m_pos = 0; m_dout_a = 0; m_dout_b = 0;
    m_vld_a = 1'b0; m_vld_b = 1'b0; m_perr_a = 1'b0; m_perr_b = 1'b0;
    repeat (hold) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Counts cycles with BUSY high while throwing random requests at both ports.
  task automatic count_busy(input string tag);
    int n = 0;
    while (BUSY === 1'b1 && n < 600) begin
      rand_req(MS - 1);
      CLR = 1'b0;
      cycle();
      n++;
    end
    check(tag, 32'(n), 32'(MS));
    idle();
  endtask

  task automatic write_a(input int a, input int d);
    idle(); EN_A = 1'b1; WE_A = 1'b1; ADDR_A = AW'(a); DIN_A = DW'(d);
    cycle();
    idle();
  endtask

  task automatic read_ab(input int a);
    idle(); EN_A = 1'b1; ADDR_A = AW'(a); EN_B = 1'b1; ADDR_B = AW'(a);
    cycle();
    idle();
  endtask

  initial begin
    RST = 1'b1;
    idle();
    @(negedge CLK);
    do_reset(3);
    count_busy("clr_len_rst");

    read_ab(0); read_ab(128); read_ab(255);

    write_a(7, 'h2A5);
    EN_B = 1'b1; ADDR_B = AW'(7);
    cycle();
    check("b_rd7", 32'(DOUT_B), 32'h2A5);
    check("b_vld7", 32'(VLD_B), 32'd1);
    idle();

    write_a(3, 'h0AA);
    EN_A = 1'b1; WE_A = 1'b1; ADDR_A = AW'(3); DIN_A = DW'('h155);
    EN_B = 1'b1; ADDR_B = AW'(3);
    cycle();
    check("collide_b", 32'(DOUT_B), (WF == 1) ? 32'h155 : 32'h0AA);
    idle();
    read_ab(3);

    write_a(300, 'h111);
    read_ab(300);
    read_ab(300 - MS);

    for (int i = 0; i < 2000; i++) begin
      rand_req(299);
      CLR = ($urandom_range(0, 399) == 0);
      cycle();
    end
    idle();
    for (int i = 0; i < 600 && BUSY === 1'b1; i++) cycle();

    for (int i = 0; i < 10; i++) write_a(i, 'h3FF);
    read_ab(0);
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    count_busy("clr_len_clr");
    for (int i = 0; i < 10; i++) read_ab(i);

    for (int i = 0; i < 10; i++) write_a(i, 'h3FF);
    read_ab(9);
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rand_req(MS - 1);
      cycle();
    end
    do_reset(2);
    count_busy("clr_len_midrst");
    for (int i = 0; i < 10; i++) read_ab(i);
    read_ab(128);

`ifdef RAM_PARITY_EN
    write_a(5, 'h123);
    write_a(6, 'h0F1);
    dut.r_mem[5][DW] = ~dut.r_mem[5][DW];
    m_flip[5] = 1'b1;
    idle(); EN_A = 1'b1; ADDR_A = AW'(5);
    cycle();
    check("perr5", 32'(PERR_A), 32'd1);
    check("perr5_vld", 32'(VLD_A), 32'd1);
    idle(); EN_A = 1'b1; ADDR_A = AW'(6);
    cycle();
    check("perr6", 32'(PERR_A), 32'd0);
    idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
